// File: rtl/pipe_reg_async_reset.sv
// Multi-stage pipeline register with per-stage valid flags.
// Supports hold, serial shift, parallel load and rotate, with a synchronous
// clear and an asynchronous active-low reset. Occupancy (fill_cnt/full/empty)
// is a popcount of the registered valid flags.
module pipe_reg_async_reset #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         valid_in,
  input  logic [WIDTH*DEPTH-1:0]       load_data,
  output logic [WIDTH-1:0]             q,
  output logic                         valid_out,
  output logic [WIDTH*DEPTH-1:0]       stages,
  output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [CW-1:0]    cnt;

  // Stage registers: reset, then clear, then enable, then the selected mode.
  // Data moves independently of the valid flags; valid only qualifies data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
      v <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
      v <= '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_SHIFT: begin
          for (int i = DEPTH - 1; i > 0; i--) begin
            data[i] <= data[i-1];
          end
          data[0] <= d;
          v       <= {v[DEPTH-2:0], valid_in};
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            data[i] <= load_data[i*WIDTH +: WIDTH];
          end
          v <= '1;
        end
        MODE_ROTATE: begin
          for (int i = DEPTH - 1; i > 0; i--) begin
            data[i] <= data[i-1];
          end
          data[0] <= data[DEPTH-1];
          v       <= {v[DEPTH-2:0], v[DEPTH-1]};
        end
        default: begin
          data <= data;
          v    <= v;
        end
      endcase
    end
  end

  // Pack every stage onto the stages bus, stage i at slice i.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_pack
      assign stages[g*WIDTH +: WIDTH] = data[g];
    end
  endgenerate

  assign q         = data[DEPTH-1];
  assign valid_out = v[DEPTH-1];

  // Occupancy is the number of set valid flags in the registered state.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CW'(v[i]);
    end
  end

  assign fill_cnt = cnt;
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);

endmodule

// File: tb/tb_pipe_reg_async_reset.sv
// Scoreboard bench for pipe_reg_async_reset: a driver applies directed and
// random stimulus, updates a queue-based reference model and pushes the
// expected post-edge state; a monitor pops and compares after each edge and
// after an asynchronous reset between edges.
module tb_pipe_reg_async_reset;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam logic [W-1:0] RV = '0;

  logic              clk;
  logic              reset;
  logic              en;
  logic              clr;
  logic [1:0]        mode;
  logic [W-1:0]      d;
  logic              valid_in;
  logic [W*D-1:0]    load_data;
  logic [W-1:0]      q;
  logic              valid_out;
  logic [W*D-1:0]    stages;
  logic [CW-1:0]     fill_cnt;
  logic              full;
  logic              empty;

  typedef struct {
    logic [W-1:0] data;
    logic         valid;
  } ent_t;

  typedef struct {
    string          name;
    logic [W-1:0]   q;
    logic           vo;
    logic [W*D-1:0] stages;
    int             fill;
    logic           full;
    logic           empty;
  } exp_t;

  ent_t pipe[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event async_ev;

  pipe_reg_async_reset #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .d(d),
    .valid_in(valid_in), .load_data(load_data), .q(q), .valid_out(valid_out),
    .stages(stages), .fill_cnt(fill_cnt), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pipe[0] is stage 0, pipe[D-1] is the output stage.
  function automatic void model_reset();
    ent_t e;
    pipe.delete();
    e.data  = RV;
    e.valid = 1'b0;
    for (int i = 0; i < D; i++) pipe.push_back(e);
  endfunction

  function automatic void push_expect(string nm);
    exp_t x;
    int   n;
    x.name = nm;
    x.q    = pipe[D-1].data;
    x.vo   = pipe[D-1].valid;
    n = 0;
    for (int i = 0; i < D; i++) begin
      x.stages[i*W +: W] = pipe[i].data;
      if (pipe[i].valid) n++;
    end
    x.fill  = n;
    x.full  = (n == D);
    x.empty = (n == 0);
    exp_q.push_back(x);
  endfunction

  function automatic void model_edge(logic r, logic e_en, logic e_clr,
                                     logic [1:0] m, logic [W-1:0] dd,
                                     logic vin, logic [W*D-1:0] ld);
    ent_t e;
    if (!r || e_clr) begin
      model_reset();
    end else if (e_en) begin
      if (m == 2'b01) begin
        e.data = dd;
        e.valid = vin;
        pipe.push_front(e);
        void'(pipe.pop_back());
      end else if (m == 2'b10) begin
        pipe.delete();
        for (int i = 0; i < D; i++) begin
          e.data = ld[i*W +: W];
          e.valid = 1'b1;
          pipe.push_back(e);
        end
      end else if (m == 2'b11) begin
        e = pipe.pop_back();
        pipe.push_front(e);
      end
    end
  endfunction

  task automatic check_val(string nm, string fld, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h", nm, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record what the next
  // rising edge should produce.
  task automatic applyStimulus(string nm, logic r, logic e_en, logic e_clr,
                               logic [1:0] m, logic [W-1:0] dd, logic vin,
                               logic [W*D-1:0] ld);
    @(negedge clk);
    reset     = r;
    en        = e_en;
    clr       = e_clr;
    mode      = m;
    d         = dd;
    valid_in  = vin;
    load_data = ld;
    model_edge(r, e_en, e_clr, m, dd, vin, ld);
    push_expect(nm);
  endtask

  task automatic checkOutput(exp_t x);
    check_val(x.name, "q",        64'(q),         64'(x.q));
    check_val(x.name, "valid_out", 64'(valid_out), 64'(x.vo));
    check_val(x.name, "stages",   64'(stages),    64'(x.stages));
    check_val(x.name, "fill_cnt", 64'(fill_cnt),  64'(x.fill));
    check_val(x.name, "full",     64'(full),      64'(x.full));
    check_val(x.name, "empty",    64'(empty),     64'(x.empty));
  endtask

  // Monitor: compare whenever the DUT outputs settle after an edge or after
  // an asynchronous reset event.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        checkOutput(x);
      end
    end
  end

  function automatic logic [W*D-1:0] rnd_ld();
    logic [W*D-1:0] r;
    for (int i = 0; i < D; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  localparam logic [W*D-1:0] LD_A = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00;
    d = '0; valid_in = 1'b0; load_data = '0;
    model_reset();

    // Held in reset regardless of other inputs
    applyStimulus("in_reset", 1'b0, 1'b1, 1'b0, 2'b10, 8'h5A, 1'b1, rnd_ld());
    applyStimulus("in_reset", 1'b0, 1'b1, 1'b0, 2'b01, 8'h3C, 1'b1, rnd_ld());

    // Shift latency: one valid word travels DEPTH enabled edges
    applyStimulus("lat_in", 1'b1, 1'b1, 1'b0, 2'b01, 8'hA5, 1'b1, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus("lat", 1'b1, 1'b1, 1'b0, 2'b01, W'($urandom), 1'b0, '0);

    // Fill to full and keep shifting
    applyStimulus("clr", 1'b1, 1'b1, 1'b0, 2'b01, 8'h00, 1'b0, '0);
    applyStimulus("clr", 1'b1, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, '0);
    for (int i = 1; i <= 5; i++)
      applyStimulus("fill", 1'b1, 1'b1, 1'b0, 2'b01, W'(i), 1'b1, '0);

    // Stall mid-shift, mode is don't-care while disabled
    applyStimulus("pre_stall", 1'b1, 1'b1, 1'b0, 2'b01, 8'hB1, 1'b1, '0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall", 1'b1, 1'b0, 1'b0, 2'($urandom), W'($urandom), 1'b1, rnd_ld());
    for (int i = 0; i < 5; i++)
      applyStimulus("resume", 1'b1, 1'b1, 1'b0, 2'b01, W'(8'hC0 + i), 1'b1, '0);

    // Load then rotate through a full cycle
    applyStimulus("load", 1'b1, 1'b1, 1'b0, 2'b10, 8'hFF, 1'b0, LD_A);
    for (int i = 0; i < 4; i++)
      applyStimulus("rotate", 1'b1, 1'b1, 1'b0, 2'b11, W'($urandom), 1'b1, rnd_ld());

    // Clear wins over an enabled load, and also acts while disabled
    applyStimulus("clr_load", 1'b1, 1'b1, 1'b1, 2'b10, 8'h77, 1'b1, LD_A);
    applyStimulus("load", 1'b1, 1'b1, 1'b0, 2'b10, 8'h00, 1'b0, LD_A);
    applyStimulus("clr_dis", 1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, LD_A);

    // Async reset between edges, checked before the next edge
    applyStimulus("load", 1'b1, 1'b1, 1'b0, 2'b10, 8'h00, 1'b0, LD_A);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    push_expect("async_reset");
    ->async_ev;
    applyStimulus("held", 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 1'b1, LD_A);
    applyStimulus("release", 1'b1, 1'b1, 1'b0, 2'b01, 8'h9E, 1'b1, '0);

    // Random traffic, occasional clear and async reset pulses
    for (int i = 0; i < 300; i++) begin
      logic r;
      r = ($urandom_range(0, 49) != 0);
      applyStimulus("rand", r, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0), 2'($urandom),
                    W'($urandom), 1'($urandom), rnd_ld());
    end

    // Every expectation must have been consumed by the monitor
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
